// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads to a one-cycle BRAM
// and buffers returned words with their PCs in a small credit-checked FIFO.
module fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_redirect,
   input  logic [63:0] i_redirect_pc,
   output logic        o_mem_read,
   output logic [13:0] o_mem_address,
   input  logic [31:0] i_mem_value,
   output logic        o_insn_valid,
   output logic [31:0] o_insn,
   output logic [63:0] o_insn_pc,
   input  logic        i_insn_ready,
   output logic        o_fault
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   insn_q [DEPTH];
   logic [31:0]   insn_d [DEPTH];
   logic [63:0]   pc_q [DEPTH];
   logic [63:0]   pc_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          inflight_q, inflight_d;
   logic [63:0]   inflight_pc_q, inflight_pc_d;
   logic          fault_q, fault_d;

   logic          issue;
   logic          kill;
   logic          push;
   logic          pop;
   logic          head_valid;
   logic [AW:0]   credit;

   // Read data lags the request by one cycle, so the only read that can
   // be in flight during a redirect returns in that same cycle: kill it there.
   always_comb begin
      credit     = count_q + (AW+1)'(inflight_q);
      kill       = i_redirect;
      issue      = i_rst_n && !fault_q && !i_redirect && (credit < DEPTH_C);
      push       = inflight_q && !kill;
      head_valid = (count_q != '0) && !fault_q;
      pop        = head_valid && i_insn_ready && !i_redirect;

      fetch_pc_d    = fetch_pc_q;
      insn_d        = insn_q;
      pc_d          = pc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      fault_d       = fault_q;

      if (i_redirect) begin
         fetch_pc_d = i_redirect_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         fault_d    = |i_redirect_pc[1:0];
      end else begin
         inflight_d = issue;
         if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 64'd4;
         end
         if (push) begin
            insn_d[wr_ptr_q] = i_mem_value;
            pc_d[wr_ptr_q]   = inflight_pc_q;
            wr_ptr_d         = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fetch_pc_q    <= RESET_PC;
         insn_q        <= '{default: '0};
         pc_q          <= '{default: '0};
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         fault_q       <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         insn_q        <= insn_d;
         pc_q          <= pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         fault_q       <= fault_d;
      end
   end

   always_comb begin
      o_mem_read    = issue;
      o_mem_address = i_rst_n ? fetch_pc_q[15:2] : 14'd0;
      o_insn_valid  = head_valid;
      o_insn        = head_valid ? insn_q[rd_ptr_q] : 32'd0;
      o_insn_pc     = head_valid ? pc_q[rd_ptr_q] : 64'd0;
      o_fault       = fault_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table vectors, hand-written corner sequences and
// random traffic checked against a queue-based reference model.
module tb_fetch_unit;

   localparam int DEPTH = 4;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_redirect;
   logic [63:0] i_redirect_pc;
   logic        o_mem_read;
   logic [13:0] o_mem_address;
   logic [31:0] i_mem_value;
   logic        o_insn_valid;
   logic [31:0] o_insn;
   logic [63:0] o_insn_pc;
   logic        i_insn_ready;
   logic        o_fault;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_mem_read    (o_mem_read),
      .o_mem_address (o_mem_address),
      .i_mem_value   (i_mem_value),
      .o_insn_valid  (o_insn_valid),
      .o_insn        (o_insn),
      .o_insn_pc     (o_insn_pc),
      .i_insn_ready  (i_insn_ready),
      .o_fault       (o_fault)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] insn;
      logic [63:0] pc;
   } ent_t;

   typedef struct {
      logic        rdy;
      logic        e_read;
      logic [13:0] e_addr;
      logic        e_valid;
      logic [31:0] e_insn;
      logic [63:0] e_pc;
   } vec_t;

   int n_err = 0;
   int n_chk = 0;

   ent_t        mq[$];
   logic        m_inf;
   logic [63:0] m_inf_pc;
   logic [63:0] m_pc;
   logic        m_fault;

   logic        cap_read;
   logic [13:0] cap_addr;
   logic        cap_valid;
   logic [31:0] cap_insn;
   logic [63:0] cap_pc;
   logic        cap_fault;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_inf    = 1'b0;
      m_inf_pc = '0;
      m_pc     = RESET_PC;
      m_fault  = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_read"},  o_mem_read,    0);
      chk({tag, "_addr"},  o_mem_address, 0);
      chk({tag, "_valid"}, o_insn_valid,  0);
      chk({tag, "_insn"},  o_insn,        0);
      chk({tag, "_pc"},    o_insn_pc,     0);
      chk({tag, "_fault"}, o_fault,       0);
   endtask

   // One clock cycle: apply inputs at edge+1, check at the falling edge,
   // advance the model at the rising edge, then present the BRAM reply.
   task automatic cyc(input logic rd, input logic [63:0] rpc,
                      input logic rdy);
      logic        e_read;
      logic        e_valid;
      logic [13:0] e_addr;
      logic [31:0] cur_mem;
      ent_t        h;
      i_redirect    = rd;
      i_redirect_pc = rpc;
      i_insn_ready  = rdy;
      e_read  = !m_fault && !rd && (mq.size() + int'(m_inf) < DEPTH);
      e_addr  = m_pc[15:2];
      e_valid = !m_fault && (mq.size() != 0);
      h       = '{insn: 32'd0, pc: 64'd0};
      if (e_valid) h = mq[0];
      #4;
      cur_mem   = i_mem_value;
      cap_read  = o_mem_read;
      cap_addr  = o_mem_address;
      cap_valid = o_insn_valid;
      cap_insn  = o_insn;
      cap_pc    = o_insn_pc;
      cap_fault = o_fault;
      chk("m_read",  cap_read,  e_read);
      chk("m_addr",  cap_addr,  e_addr);
      chk("m_valid", cap_valid, e_valid);
      chk("m_insn",  cap_insn,  h.insn);
      chk("m_pc",    cap_pc,    h.pc);
      chk("m_fault", cap_fault, m_fault);
      @(posedge i_clk);
      #1;
      if (rd) begin
         mq.delete();
         m_inf   = 1'b0;
         m_pc    = rpc;
         m_fault = |rpc[1:0];
      end else begin
         if (e_valid && rdy) void'(mq.pop_front());
         if (m_inf) mq.push_back('{insn: cur_mem, pc: m_inf_pc});
         m_inf    = e_read;
         m_inf_pc = m_pc;
         if (e_read) m_pc = m_pc + 64'd4;
      end
      i_mem_value = e_read ? 32'h1000 + 32'(e_addr) : $urandom;
   endtask

   initial begin
      logic        rd;
      logic [63:0] rpc;
      logic        rdy;

      tbl[0]  = '{1'b0, 1'b1, 14'd0, 1'b0, 32'h0,    64'h0};
      tbl[1]  = '{1'b0, 1'b1, 14'd1, 1'b0, 32'h0,    64'h0};
      tbl[2]  = '{1'b0, 1'b1, 14'd2, 1'b1, 32'h1000, 64'h0};
      tbl[3]  = '{1'b0, 1'b1, 14'd3, 1'b1, 32'h1000, 64'h0};
      tbl[4]  = '{1'b0, 1'b0, 14'd4, 1'b1, 32'h1000, 64'h0};
      tbl[5]  = '{1'b0, 1'b0, 14'd4, 1'b1, 32'h1000, 64'h0};
      tbl[6]  = '{1'b1, 1'b0, 14'd4, 1'b1, 32'h1000, 64'h0};
      tbl[7]  = '{1'b1, 1'b1, 14'd4, 1'b1, 32'h1001, 64'h4};
      tbl[8]  = '{1'b1, 1'b1, 14'd5, 1'b1, 32'h1002, 64'h8};
      tbl[9]  = '{1'b1, 1'b1, 14'd6, 1'b1, 32'h1003, 64'hC};
      tbl[10] = '{1'b1, 1'b1, 14'd7, 1'b1, 32'h1004, 64'h10};

      i_rst_n       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = '0;
      i_insn_ready  = 1'b0;
      i_mem_value   = '0;
      model_reset();
      #1;
      chk_reset("rst0");
      @(posedge i_clk);
      #1;
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;

      // Backpressure from reset, then drain.
      for (int i = 0; i < 11; i++) begin
         cyc(1'b0, 64'h0, tbl[i].rdy);
         chk($sformatf("t%0d_read", i),  cap_read,  tbl[i].e_read);
         chk($sformatf("t%0d_addr", i),  cap_addr,  tbl[i].e_addr);
         chk($sformatf("t%0d_valid", i), cap_valid, tbl[i].e_valid);
         chk($sformatf("t%0d_insn", i),  cap_insn,  tbl[i].e_insn);
         chk($sformatf("t%0d_pc", i),    cap_pc,    tbl[i].e_pc);
      end

      // Redirect with two buffered words and a read in flight.
      cyc(1'b1, 64'h100, 1'b0);
      cyc(1'b0, 64'h0, 1'b1);
      chk("rd100_valid", cap_valid, 0);
      chk("rd100_read",  cap_read,  1);
      chk("rd100_addr",  cap_addr,  14'h40);
      cyc(1'b0, 64'h0, 1'b1);
      chk("rd100_valid2", cap_valid, 0);
      cyc(1'b0, 64'h0, 1'b1);
      chk("rd100_hvalid", cap_valid, 1);
      chk("rd100_hpc",    cap_pc,    64'h100);
      chk("rd100_hinsn",  cap_insn,  32'h1040);

      // Misaligned redirect faults until an aligned one.
      cyc(1'b1, 64'h102, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 64'h0, 1'b1);
         chk("flt_fault", cap_fault, 1);
         chk("flt_read",  cap_read,  0);
         chk("flt_valid", cap_valid, 0);
      end
      cyc(1'b1, 64'h200, 1'b1);
      cyc(1'b0, 64'h0, 1'b1);
      chk("clr_fault", cap_fault, 0);
      chk("clr_read",  cap_read,  1);
      chk("clr_addr",  cap_addr,  14'h80);

      // Address wrap at the top of the BRAM window.
      cyc(1'b1, 64'hFFFC, 1'b1);
      cyc(1'b0, 64'h0, 1'b1);
      chk("wrap_addr0", cap_addr, 14'h3FFF);
      cyc(1'b0, 64'h0, 1'b1);
      chk("wrap_addr1", cap_addr, 14'h0000);
      cyc(1'b0, 64'h0, 1'b1);
      chk("wrap_pc0",   cap_pc,   64'hFFFC);
      chk("wrap_insn0", cap_insn, 32'h4FFF);
      cyc(1'b0, 64'h0, 1'b1);
      chk("wrap_pc1",   cap_pc,   64'h10000);
      chk("wrap_insn1", cap_insn, 32'h1000);

      for (int i = 0; i < 400; i++) begin
         rd  = ($urandom_range(0, 19) == 0);
         rpc = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         rdy = ($urandom_range(0, 3) != 0);
         cyc(rd, rpc, rdy);
      end

      // Reset asserted between edges with data buffered.
      cyc(1'b1, 64'h400, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 64'h0, 1'b0);
      i_redirect = 1'b0;
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_reset("rst1");
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      model_reset();
      i_mem_value = 32'hDEADBEEF;
      cyc(1'b0, 64'h0, 1'b1);
      chk("rel_read", cap_read, 1);
      chk("rel_addr", cap_addr, 0);
      cyc(1'b0, 64'h0, 1'b1);
      chk("rel_valid0", cap_valid, 0);
      cyc(1'b0, 64'h0, 1'b1);
      chk("rel_insn", cap_insn, 32'h1000);
      chk("rel_pc",   cap_pc,   64'h0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 64'h0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
